// File: rtl/deal_pkg.sv
`default_nettype none
// ============================================================================
// Module      : deal_pkg
// Description : Shared types and constants for the deal sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package deal_pkg;

    typedef enum logic [2:0] {
        ANIM_IDLE     = 3'd0,
        ANIM_DOWN     = 3'd1,
        ANIM_UP       = 3'd2,
        ANIM_STRAIGHT = 3'd3
    } anim_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_HOLD    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4
    } deal_state_t;

    localparam int FRAME_CNT_W = 8;

    function automatic anim_t dir_to_anim(input logic [1:0] dir);
        return anim_t'({1'b0, dir});
    endfunction

endpackage
`default_nettype wire

// File: rtl/deal_fifo.sv
`default_nettype none
// ============================================================================
// Module      : deal_fifo
// Description : Synchronous FIFO holding pending deal directions.
// Revision    : 1.0 - initial release
// ============================================================================
module deal_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_cw-1:0]  r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // A full FIFO rejects a push even when a pop happens in the same cycle.
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    assign full  = (r_count == c_cw'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cw'(1);
                2'b01:   r_count <= r_count - c_cw'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/deal_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : deal_sequencer
// Description : Queues deal requests and walks each card through the animation
//               stage. Define DEAL_TIMEOUT_EN to enable the frame watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module deal_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int HOLD_FRAMES    = 2,
    parameter int TIMEOUT_FRAMES = 120
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            frame_start,
    input  logic                            req_valid,
    input  logic [1:0]                      req_dir,
    output logic                            req_ready,
    output logic [2:0]                      animation,
    input  logic                            animation_end,
    output logic                            card_done,
    output logic [1:0]                      card_dir,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] pending,
    output logic                            timeout_err
);
    import deal_pkg::*;

    localparam logic [FRAME_CNT_W-1:0] c_hold_frames = FRAME_CNT_W'(HOLD_FRAMES);
`ifdef DEAL_TIMEOUT_EN
    localparam logic [FRAME_CNT_W-1:0] c_timeout_frames = FRAME_CNT_W'(TIMEOUT_FRAMES);
`endif

    deal_state_t            r_state;
    logic [1:0]             r_dir;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;
    logic [FRAME_CNT_W-1:0] w_frame_cnt_inc;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic [1:0]             w_head;

    assign req_ready = !w_full;
    // Direction 0 completes the handshake but never becomes a card.
    assign w_push    = req_valid && !w_full && (req_dir != 2'd0);
    assign w_pop     = (r_state == ST_IDLE) && !w_empty;
    assign w_frame_cnt_inc = (frame_start && (r_frame_cnt != '1))
                           ? r_frame_cnt + FRAME_CNT_W'(1) : r_frame_cnt;

    deal_fifo #(
        .WIDTH (2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (req_dir),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (pending)
    );

`ifndef DEAL_TIMEOUT_EN
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_dir       <= 2'd0;
            r_frame_cnt <= '0;
            animation   <= ANIM_IDLE;
            card_done   <= 1'b0;
            card_dir    <= 2'd0;
            busy        <= 1'b0;
`ifdef DEAL_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
        end else begin
            card_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_dir       <= w_head;
                        animation   <= dir_to_anim(w_head);
                        r_frame_cnt <= '0;
                        busy        <= 1'b1;
                        r_state     <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    // Counter is cleared on every transition so a pulse in
                    // the transition cycle never counts for the new state.
                    if (animation_end) begin
                        r_frame_cnt <= '0;
                        r_state     <= ST_HOLD;
`ifdef DEAL_TIMEOUT_EN
                    end else if (w_frame_cnt_inc >= c_timeout_frames) begin
                        timeout_err <= 1'b1;
                        animation   <= ANIM_IDLE;
                        r_frame_cnt <= '0;
                        r_state     <= ST_RELEASE;
                    end else begin
                        r_frame_cnt <= w_frame_cnt_inc;
`endif
                    end
                end
                ST_HOLD: begin
                    if (w_frame_cnt_inc >= c_hold_frames) begin
                        animation   <= ANIM_IDLE;
                        r_frame_cnt <= '0;
                        r_state     <= ST_RELEASE;
                    end else begin
                        r_frame_cnt <= w_frame_cnt_inc;
                    end
                end
                ST_RELEASE: begin
                    if (!animation_end) begin
                        card_done <= 1'b1;
                        card_dir  <= r_dir;
                        r_state   <= ST_DONE;
`ifdef DEAL_TIMEOUT_EN
                    end else if (w_frame_cnt_inc >= c_timeout_frames) begin
                        timeout_err <= 1'b1;
                        card_done   <= 1'b1;
                        card_dir    <= r_dir;
                        r_state     <= ST_DONE;
                    end else begin
                        r_frame_cnt <= w_frame_cnt_inc;
`endif
                    end
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    animation <= ANIM_IDLE;
                    busy      <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_deal_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_deal_sequencer
// Description : Self-checking bench for deal_sequencer (main instance plus a
//               HOLD_FRAMES=0 instance); watchdog checks need DEAL_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_deal_sequencer;

    localparam int DEPTH = 4;
    localparam int TMO   = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_dir = 2'd0;
    logic       aend = 1'b0;
    logic       req_ready, card_done, busy, timeout_err;
    logic [2:0] animation;
    logic [1:0] card_dir;
    logic [2:0] pending;

    logic       req_valid0 = 1'b0;
    logic [1:0] req_dir0 = 2'd0;
    logic       aend0 = 1'b0;
    logic       req_ready0, card_done0, busy0, timeout_err0;
    logic [2:0] animation0;
    logic [1:0] card_dir0;
    logic [2:0] pending0;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    bit         auto_anim = 0;
    bit         auto_frames = 0;
    logic [1:0] done_q[$];
    int         gap_q[$];
    int         last_done = -1;
    logic [2:0] prev_anim = 3'd0;

    always #5 clk = ~clk;

    deal_sequencer #(.FIFO_DEPTH(DEPTH), .HOLD_FRAMES(2), .TIMEOUT_FRAMES(TMO)) u_dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .req_valid(req_valid),
        .req_dir(req_dir), .req_ready(req_ready), .animation(animation),
        .animation_end(aend), .card_done(card_done), .card_dir(card_dir),
        .busy(busy), .pending(pending), .timeout_err(timeout_err)
    );

    deal_sequencer #(.FIFO_DEPTH(DEPTH), .HOLD_FRAMES(0), .TIMEOUT_FRAMES(TMO)) u_dut0 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .req_valid(req_valid0),
        .req_dir(req_dir0), .req_ready(req_ready0), .animation(animation0),
        .animation_end(aend0), .card_done(card_done0), .card_dir(card_dir0),
        .busy(busy0), .pending(pending0), .timeout_err(timeout_err0)
    );

    // One clock of simulated time: optional animation-stage/frame emulation,
    // then record card completions and the gap to the next launch.
    task automatic step();
        if (auto_anim) begin
            if (animation != 3'd0 && !aend && $urandom_range(0, 2) == 0) aend = 1'b1;
            else if (animation == 3'd0 && aend && $urandom_range(0, 2) == 0) aend = 1'b0;
        end
        if (auto_frames) frame_start = (cyc % 4 == 3);
        @(posedge clk);
        #1;
        cyc++;
        if (card_done) begin
            done_q.push_back(card_dir);
            last_done = cyc;
        end
        if (animation != 3'd0 && prev_anim == 3'd0 && last_done >= 0) begin
            gap_q.push_back(cyc - last_done);
            last_done = -1;
        end
        prev_anim = animation;
    endtask

    task automatic do_reset();
        auto_anim = 0; auto_frames = 0;
        req_valid = 0; req_dir = 0; aend = 0; frame_start = 0;
        req_valid0 = 0; aend0 = 0;
        rst = 1; step(); step(); rst = 0;
        done_q.delete(); gap_q.delete(); last_done = -1;
    endtask

    task automatic test_reset();
        rst = 1; step(); step();
        checks++; if (animation !== 3'd0) begin errors++; $display("FAIL reset_anim got %0d want 0", animation); end
        checks++; if (card_done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", card_done); end
        checks++; if (card_dir !== 2'd0) begin errors++; $display("FAIL reset_dir got %0d want 0", card_dir); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (pending !== 3'd0) begin errors++; $display("FAIL reset_pending got %0d want 0", pending); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_tmo got %0b want 0", timeout_err); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", req_ready); end
        rst = 0;
    endtask

    task automatic test_single();
        logic [1:0] d = 2'($urandom_range(1, 3));
        do_reset();
        req_valid = 1; req_dir = d;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %0b want 1", req_ready); end
        step(); req_valid = 0;
        checks++; if (pending !== 3'd1 || animation !== 3'd0) begin errors++; $display("FAIL single_n1 pending %0d anim %0d want 1 0", pending, animation); end
        step();
        checks++; if (animation !== {1'b0, d} || busy !== 1'b1) begin errors++; $display("FAIL single_n2 anim %0d busy %0b want %0d 1", animation, busy, d); end
        repeat ($urandom_range(1, 4)) step();
        // Frame pulse coincident with the LAUNCH->HOLD step must not count.
        aend = 1; frame_start = 1; step(); frame_start = 0;
        repeat ($urandom_range(0, 2)) step();
        frame_start = 1; step(); frame_start = 0;
        checks++; if (animation !== {1'b0, d}) begin errors++; $display("FAIL single_hold1 anim %0d want %0d", animation, d); end
        repeat ($urandom_range(0, 2)) step();
        frame_start = 1; step(); frame_start = 0;
        checks++; if (animation !== 3'd0) begin errors++; $display("FAIL single_hold2 anim %0d want 0", animation); end
        step(); step();
        checks++; if (card_done !== 1'b0 || done_q.size() != 0) begin errors++; $display("FAIL single_release_wait done %0b want 0", card_done); end
        aend = 0; step();
        checks++; if (card_done !== 1'b1 || card_dir !== d) begin errors++; $display("FAIL single_done done %0b dir %0d want 1 %0d", card_done, card_dir, d); end
        step();
        checks++; if (card_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_after done %0b busy %0b want 0 0", card_done, busy); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_q[$];
        logic [1:0] seq[4] = '{2'd1, 2'd2, 2'd3, 2'd1};
        logic [1:0] d0 = 2'($urandom_range(1, 3));
        do_reset();
        exp_q.push_back(d0);
        req_valid = 1; req_dir = d0; step(); req_valid = 0; step();
        for (int i = 0; i < 4; i++) begin
            req_valid = 1; req_dir = seq[i]; exp_q.push_back(seq[i]); step();
        end
        req_dir = 2'd2;
        checks++; if (pending !== 3'd4 || req_ready !== 1'b0) begin errors++; $display("FAIL fill_full pending %0d ready %0b want 4 0", pending, req_ready); end
        step(); req_valid = 0;
        checks++; if (pending !== 3'd4) begin errors++; $display("FAIL fill_fifth pending %0d want 4", pending); end
        auto_anim = 1; auto_frames = 1;
        for (int i = 0; i < 3000 && done_q.size() < 5; i++) step();
        checks++; if (done_q.size() != 5) begin errors++; $display("FAIL fill_count got %0d want 5", done_q.size()); end
        for (int i = 0; i < 5 && i < done_q.size(); i++) begin
            checks++; if (done_q[i] !== exp_q[i]) begin errors++; $display("FAIL fill_order[%0d] got %0d want %0d", i, done_q[i], exp_q[i]); end
        end
        checks++; if (gap_q.size() != 4) begin errors++; $display("FAIL gap_count got %0d want 4", gap_q.size()); end
        foreach (gap_q[i]) begin
            checks++; if (gap_q[i] != 2) begin errors++; $display("FAIL gap[%0d] got %0d want 2", i, gap_q[i]); end
        end
    endtask

    task automatic test_noop();
        do_reset();
        req_valid = 1; req_dir = 2'd0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL noop_ready got %0b want 1", req_ready); end
        step(); req_valid = 0;
        checks++; if (pending !== 3'd0) begin errors++; $display("FAIL noop_pending got %0d want 0", pending); end
        repeat (6) step();
        checks++; if (done_q.size() != 0 || animation !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL noop_idle dones %0d anim %0d busy %0b want 0 0 0", done_q.size(), animation, busy); end
    endtask

    task automatic test_random();
        logic [1:0] exp_q[$];
        do_reset();
        auto_anim = 1; auto_frames = 1;
        for (int i = 0; i < 400; i++) begin
            req_valid = ($urandom_range(0, 2) == 0);
            req_dir = 2'($urandom_range(0, 3));
            checks++; if (req_ready !== (pending != 3'(DEPTH)) || pending > 3'(DEPTH)) begin errors++; $display("FAIL rand_ready ready %0b pending %0d", req_ready, pending); end
            if (req_valid && req_ready && req_dir != 2'd0) exp_q.push_back(req_dir);
            step();
        end
        req_valid = 0;
        for (int i = 0; i < 5000 && (done_q.size() < exp_q.size() || busy || pending != 0); i++) step();
        checks++; if (done_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", done_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < done_q.size(); i++) begin
            checks++; if (done_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_order[%0d] got %0d want %0d", i, done_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid = 1; req_dir = 2'($urandom_range(1, 3)); step();
        req_valid = 0; step();
        req_valid = 1;
        req_dir = 2'($urandom_range(1, 3)); step();
        req_dir = 2'($urandom_range(1, 3)); step();
        req_valid = 0;
        aend = 1; step(); step();
        checks++; if (pending !== 3'd2 || busy !== 1'b1) begin errors++; $display("FAIL mid_pre pending %0d busy %0b want 2 1", pending, busy); end
        rst = 1; aend = 0; step(); rst = 0;
        checks++; if (animation !== 3'd0 || pending !== 3'd0 || busy !== 1'b0 || card_done !== 1'b0) begin
            errors++; $display("FAIL mid_reset anim %0d pending %0d busy %0b done %0b want 0 0 0 0", animation, pending, busy, card_done);
        end
        auto_anim = 1; auto_frames = 1;
        repeat (30) step();
        checks++; if (done_q.size() != 0 || animation !== 3'd0) begin errors++; $display("FAIL mid_dropped dones %0d anim %0d want 0 0", done_q.size(), animation); end
    endtask

    task automatic test_hold_zero();
        logic [1:0] d = 2'($urandom_range(1, 3));
        do_reset();
        req_valid0 = 1; req_dir0 = d; step(); req_valid0 = 0; step();
        checks++; if (animation0 !== {1'b0, d}) begin errors++; $display("FAIL h0_launch anim %0d want %0d", animation0, d); end
        aend0 = 1; step();
        checks++; if (animation0 !== {1'b0, d}) begin errors++; $display("FAIL h0_hold anim %0d want %0d", animation0, d); end
        step();
        checks++; if (animation0 !== 3'd0) begin errors++; $display("FAIL h0_drop anim %0d want 0", animation0); end
        aend0 = 0; step();
        checks++; if (card_done0 !== 1'b1 || card_dir0 !== d) begin errors++; $display("FAIL h0_done done %0b dir %0d want 1 %0d", card_done0, card_dir0, d); end
    endtask

`ifdef DEAL_TIMEOUT_EN
    task automatic test_timeout();
        logic [1:0] d = 2'($urandom_range(1, 3));
        do_reset();
        req_valid = 1; req_dir = d; step(); req_valid = 0; step();
        for (int k = 0; k < TMO - 1; k++) begin
            repeat ($urandom_range(1, 3)) step();
            frame_start = 1; step(); frame_start = 0;
        end
        checks++; if (timeout_err !== 1'b0 || animation !== {1'b0, d}) begin errors++; $display("FAIL tmo_early err %0b anim %0d want 0 %0d", timeout_err, animation, d); end
        step();
        frame_start = 1; step(); frame_start = 0;
        checks++; if (timeout_err !== 1'b1 || animation !== 3'd0) begin errors++; $display("FAIL tmo_fire err %0b anim %0d want 1 0", timeout_err, animation); end
        step();
        checks++; if (card_done !== 1'b1 || card_dir !== d) begin errors++; $display("FAIL tmo_done done %0b dir %0d want 1 %0d", card_done, card_dir, d); end
        done_q.delete();
        req_valid = 1; req_dir = 2'($urandom_range(1, 3)); step(); req_valid = 0;
        auto_anim = 1; auto_frames = 1;
        for (int i = 0; i < 500 && done_q.size() < 1; i++) step();
        checks++; if (done_q.size() != 1 || timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky dones %0d err %0b want 1 1", done_q.size(), timeout_err); end
    endtask
`else
    task automatic test_timeout();
        logic [1:0] d = 2'($urandom_range(1, 3));
        do_reset();
        req_valid = 1; req_dir = d; step(); req_valid = 0; step();
        auto_frames = 1;
        repeat (200) step();
        checks++; if (timeout_err !== 1'b0 || animation !== {1'b0, d} || busy !== 1'b1) begin
            errors++; $display("FAIL no_tmo err %0b anim %0d busy %0b want 0 %0d 1", timeout_err, animation, busy, d);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_noop();
        test_random();
        test_reset_mid();
        test_hold_zero();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/deal_sequencer.md
Name: deal_sequencer

Overview:
- Sits directly upstream of the card animation stage in the blackjack display path.
- Accepts deal requests from game logic and buffers them in a small FIFO.
- Drives the 3-bit animation code for one card at a time, using the animation stage's animation_end handshake.
- Pulses card_done once a card has landed, dwelt, and been released, so game logic can draw the static card and advance.

Parameters:
- FIFO_DEPTH, 4: number of buffered deal requests (power of 2, >= 2).
- HOLD_FRAMES, 2: frame_start pulses the card dwells at its destination after animation_end rises.
- TIMEOUT_FRAMES, 120: watchdog limit in frames. Used only when DEAL_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse at hcount==0 && vcount==0
- req_valid  in  1  deal request valid
- req_dir  in  2  path code: 1=DOWN, 2=UP, 3=STRAIGHT, 0=no-op
- req_ready  out  1  request can be accepted (FIFO not full)
- animation  out  3  code to the animation stage; 0 = idle/release
- animation_end  in  1  high while the animation stage is in STOP/RESET
- card_done  out  1  one-cycle pulse per completed card
- card_dir  out  2  dir of the completed card; valid while card_done=1
- busy  out  1  state != IDLE
- pending  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset (rst, clk): reset is synchronous, active-high on clock clk.
  - Reset values: state=IDLE, FIFO emptied, animation=0, card_done=0, card_dir=0, busy=0, pending=0, timeout_err=0, frame counter=0.
  - Reset mid-operation aborts the current card and drops all queued requests; animation returns to 0 the next cycle.
- Handshake:
  - Transfer occurs when req_valid && req_ready.
  - req_ready = !full, combinational from FIFO count.
  - A pop in the same cycle does not admit a push when full.
  - req_dir==0 is accepted (consumed) but not enqueued.
- FIFO: first-in first-out, pointer wrap modulo FIFO_DEPTH. pending updates the cycle after a push or pop.
- All outputs are registered except req_ready.
- FSM states: IDLE, LAUNCH, HOLD, RELEASE, DONE.
  - IDLE: if FIFO non-empty, pop the head, latch dir, animation<=dir, go to LAUNCH. Otherwise stay, animation=0.
  - LAUNCH: hold animation=dir. On animation_end==1: clear frame counter, go to HOLD.
  - HOLD: hold animation=dir. Count frame_start pulses. When count reaches HOLD_FRAMES: animation<=0, go to RELEASE.
    - HOLD_FRAMES==0 goes to RELEASE on the next cycle.
  - RELEASE: animation=0. On animation_end==0 (animation stage back in IDLE), go to DONE.
  - DONE: card_done=1 for exactly one cycle, card_dir=latched dir, then go to IDLE.
- Latency:
  - Request accepted in cycle N into an empty FIFO with state IDLE: pop in N+1, animation valid in N+2.
  - Back-to-back cards: the next pop happens in the IDLE cycle after DONE. Minimum 2 cycles from card_done to the next animation!=0.
- animation_end is sampled level-sensitively. A stale high value on entering LAUNCH is not possible, because RELEASE waits for it to fall.
- Frame counter is 8 bits and saturates. frame_start arriving in the same cycle as a state change is not counted for the new state.

Optional Feature:
- Macro: DEAL_TIMEOUT_EN.
- Defined: in LAUNCH and RELEASE, count frame_start pulses.
  - Reaching TIMEOUT_FRAMES sets timeout_err (sticky until rst).
  - LAUNCH then forces animation<=0 and goes to RELEASE.
  - RELEASE then goes to DONE; card_done is still pulsed.
- Undefined: no watchdog; LAUNCH and RELEASE wait indefinitely; timeout_err tied to 0.

Decomposition:
- Package deal_pkg:
  - typedef enum logic [2:0] anim_t {ANIM_IDLE=0, ANIM_DOWN=1, ANIM_UP=2, ANIM_STRAIGHT=3}.
  - typedef enum logic [2:0] deal_state_t.
  - localparam FRAME_CNT_W=8.
- Sub-module deal_fifo: synchronous FIFO, parameters WIDTH=2 and DEPTH, with push, pop, dout, full, empty, count.

Test Plan:
- Reset, then a single request dir=1. Required response:
  - animation=1 two cycles after acceptance.
  - After animation_end rises: 2 frame_start pulses, then animation=0.
  - Lower animation_end: card_done pulse with card_dir=1, busy=0.
- Push dirs 1,2,3,1 back to back with no pops. Required response:
  - pending=4 and req_ready=0; a 5th req_valid is not accepted.
  - Cards complete in order 1,2,3,1.
- Request with req_dir=0. Required response: req_ready handshake completes, pending stays 0, no card_done, animation stays 0.
- Assert rst while in HOLD with 2 entries queued. Required response: the next cycle shows animation=0, pending=0, busy=0, and no card_done.
- HOLD_FRAMES=0. Required response: animation drops to 0 one cycle after animation_end rises.
- DEAL_TIMEOUT_EN defined, TIMEOUT_FRAMES=5, animation_end held 0 for 5 frame_start pulses. Required response:
  - timeout_err=1, animation=0, card_done pulses.
  - timeout_err stays 1 after later successful cards.
